// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Purpose  : Registered ALU issue stage: opcode decode, operand-B select/extend,
//            valid/ready output with a 2-entry (output + skid) buffer.
// Revision : 1.0
// ============================================================================
module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    input  logic [IMM_W-1:0]  in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_select,
    output logic [CNT_W-1:0]  illegal_count
);

    localparam logic [1:0]       c_SEL_ADD = 2'b00;
    localparam logic [1:0]       c_SEL_AND = 2'b01;
    localparam logic [1:0]       c_SEL_OR  = 2'b10;
    localparam logic [1:0]       c_SEL_SLL = 2'b11;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic              r_o_valid;
    logic [DATA_W-1:0] r_o_a;
    logic [DATA_W-1:0] r_o_b;
    logic [1:0]        r_o_sel;
    logic              r_s_valid;
    logic [DATA_W-1:0] r_s_a;
    logic [DATA_W-1:0] r_s_b;
    logic [1:0]        r_s_sel;
    logic [CNT_W-1:0]  r_illegal_count;

    logic              w_legal;
    logic [DATA_W-1:0] w_b;
    logic [1:0]        w_sel;
    logic [DATA_W-1:0] w_sx;
    logic [DATA_W-1:0] w_zx;
    logic              w_accept;
    logic              w_accept_legal;
    logic              w_accept_illegal;
    logic              w_emit;

    assign w_sx = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    assign w_zx = {{(DATA_W-IMM_W){1'b0}}, in_imm};

    always_comb begin
        w_legal = 1'b1;
        w_b     = in_rt_val;
        w_sel   = c_SEL_ADD;
        case (in_op)
            4'b0000: begin w_b = in_rt_val;    w_sel = c_SEL_ADD; end
            4'b0001: begin w_b = in_rt_val;    w_sel = c_SEL_AND; end
            4'b0010: begin w_b = in_rt_val;    w_sel = c_SEL_OR;  end
            4'b0011: begin w_b = '0;           w_sel = c_SEL_SLL; end
            4'b0100: begin w_b = w_sx;         w_sel = c_SEL_ADD; end
            4'b0101: begin w_b = w_zx;         w_sel = c_SEL_AND; end
            4'b0110: begin w_b = w_zx;         w_sel = c_SEL_OR;  end
            4'b0111: begin w_b = w_sx;         w_sel = c_SEL_ADD; end
            default: begin w_legal = 1'b0; end
        endcase
    end

    // in_ready is purely the registered skid-empty flag, so no out_ready path.
    assign in_ready         = !r_s_valid;
    assign w_accept         = in_valid && in_ready;
    assign w_accept_legal   = w_accept && w_legal;
    assign w_accept_illegal = w_accept && !w_legal;
    assign w_emit           = r_o_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o_valid <= 1'b0;
            r_o_a     <= '0;
            r_o_b     <= '0;
            r_o_sel   <= c_SEL_ADD;
            r_s_valid <= 1'b0;
            r_s_a     <= '0;
            r_s_b     <= '0;
            r_s_sel   <= c_SEL_ADD;
        end else if (w_emit && r_s_valid) begin
            r_o_a     <= r_s_a;
            r_o_b     <= r_s_b;
            r_o_sel   <= r_s_sel;
            r_s_valid <= 1'b0;
        end else if (!r_o_valid || w_emit) begin
            r_o_valid <= w_accept_legal;
            if (w_accept_legal) begin
                r_o_a   <= in_rs_val;
                r_o_b   <= w_b;
                r_o_sel <= w_sel;
            end
        end else if (w_accept_legal) begin
            r_s_valid <= 1'b1;
            r_s_a     <= in_rs_val;
            r_s_b     <= w_b;
            r_s_sel   <= w_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_count <= '0;
        end else if (w_accept_illegal && (r_illegal_count != c_CNT_MAX)) begin
            r_illegal_count <= r_illegal_count + 1'b1;
        end
    end

    assign out_valid     = r_o_valid;
    assign alu_a         = r_o_a;
    assign alu_b         = r_o_b;
    assign alu_select    = r_o_sel;
    assign illegal_count = r_illegal_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Purpose  : Randomized + directed bench for alu_operand_stage against a
//            FIFO-of-results reference model.
// Revision : 1.0
// ============================================================================
module tb_alu_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_select;
    logic [7:0]  illegal_count;

    alu_operand_stage #(.DATA_W(32), .IMM_W(16), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_rs_val    (in_rs_val),
        .in_rt_val    (in_rt_val),
        .in_imm       (in_imm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_select   (alu_select),
        .illegal_count(illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [65:0] q[$];
    int          cnt_model = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected ALU entry {a, b, select}; select encodes add/and/or/sll2 as 0..3.
    function automatic logic [65:0] expect_of(input logic [3:0] op, input logic [31:0] rs,
                                              input logic [31:0] rt, input logic [15:0] imm);
        logic [31:0] sx;
        logic [31:0] zx;
        sx = 32'($signed(imm));
        zx = 32'(imm);
        case (op)
            4'd0:    return {rs, rt, 2'd0};
            4'd1:    return {rs, rt, 2'd1};
            4'd2:    return {rs, rt, 2'd2};
            4'd3:    return {rs, 32'd0, 2'd3};
            4'd4:    return {rs, sx, 2'd0};
            4'd5:    return {rs, zx, 2'd1};
            4'd6:    return {rs, zx, 2'd2};
            default: return {rs, sx, 2'd0};
        endcase
    endfunction

    // One clock cycle, entered and left at a negedge.
    task automatic cycle(input logic v, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [15:0] imm, input logic ordy);
        logic [65:0] e;
        bit          ready_m;
        in_valid  = v;
        in_op     = op;
        in_rs_val = rs;
        in_rt_val = rt;
        in_imm    = imm;
        out_ready = ordy;
        #1;
        ready_m = (q.size() < 2);
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("in_ready", 64'(in_ready), 64'(ready_m));
        check("illegal_count", 64'(illegal_count), 64'(cnt_model));
        if (q.size() > 0 && out_valid) begin
            e = q[0];
            check("alu_a", 64'(alu_a), 64'(e[65:34]));
            check("alu_b", 64'(alu_b), 64'(e[33:2]));
            check("alu_select", 64'(alu_select), 64'(e[1:0]));
            if (ordy) void'(q.pop_front());
        end
        if (v && ready_m) begin
            if (op < 4'd8) q.push_back(expect_of(op, rs, rt, imm));
            else if (cnt_model < 255) cnt_model++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 4'd0, 32'd0, 32'd0, 16'd0, ordy);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_rs_val = '0;
        in_rt_val = '0;
        in_imm    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset alu_a", 64'(alu_a), 64'd0);
        check("reset alu_b", 64'(alu_b), 64'd0);
        check("reset illegal_count", 64'(illegal_count), 64'd0);
        rst_n = 1'b1;
        check("in_ready after reset", 64'(in_ready), 64'd1);

        // Directed decode cases
        cycle(1'b1, 4'd0, 32'h5, 32'h7, 16'h0, 1'b1);
        check("ADD b", 64'(alu_b), 64'h7);
        cycle(1'b1, 4'd4, 32'h10, 32'h0, 16'hFFFC, 1'b1);
        check("ADDI b", 64'(alu_b), 64'hFFFF_FFFC);
        cycle(1'b1, 4'd6, 32'h1, 32'h0, 16'h8001, 1'b1);
        check("ORI b", 64'(alu_b), 64'h0000_8001);
        check("ORI sel", 64'(alu_select), 64'd2);
        cycle(1'b1, 4'd3, 32'h3, 32'hDEAD, 16'h1234, 1'b1);
        check("SLL2 b", 64'(alu_b), 64'd0);
        check("SLL2 sel", 64'(alu_select), 64'd3);
        idle(1'b1);

        // Back-pressure: three ADDs offered, two fit, third waits
        cycle(1'b1, 4'd0, 32'h0, 32'h1, 16'h0, 1'b0);
        cycle(1'b1, 4'd0, 32'h0, 32'h2, 16'h0, 1'b0);
        check("bp in_ready low", 64'(in_ready), 64'd0);
        check("bp holds rt=1", 64'(alu_b), 64'h1);
        cycle(1'b1, 4'd0, 32'h0, 32'h3, 16'h0, 1'b0);
        cycle(1'b1, 4'd0, 32'h0, 32'h3, 16'h0, 1'b1);
        cycle(1'b1, 4'd0, 32'h0, 32'h3, 16'h0, 1'b1);
        repeat (3) idle(1'b1);

        // Illegal opcodes interleaved with ANDs
        cycle(1'b1, 4'd1, 32'hF0F0, 32'hFF00, 16'h0, 1'b1);
        cycle(1'b1, 4'h9, 32'h1, 32'h1, 16'h1, 1'b1);
        cycle(1'b1, 4'hF, 32'h2, 32'h2, 16'h2, 1'b1);
        cycle(1'b1, 4'd1, 32'h0F0F, 32'h00FF, 16'h0, 1'b1);
        repeat (2) idle(1'b1);
        check("illegal_count=2", 64'(illegal_count), 64'd2);

        // Continuous streaming, one result per cycle
        for (int i = 0; i < 40; i++)
            cycle(1'b1, 4'($urandom_range(0, 7)), $urandom, $urandom, 16'($urandom), 1'b1);
        repeat (2) idle(1'b1);

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 600; i++)
            cycle(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), $urandom, $urandom,
                  16'($urandom), ($urandom_range(0, 9) < 6));
        repeat (3) idle(1'b1);

        // Counter saturation
        for (int i = 0; i < 300; i++)
            cycle(1'b1, 4'($urandom_range(8, 15)), $urandom, $urandom, 16'($urandom), 1'b1);
        idle(1'b1);
        check("illegal_count saturated", 64'(illegal_count), 64'd255);

        // Reset with both entries full and the ALU stalled
        cycle(1'b1, 4'd0, 32'hA, 32'hB, 16'h0, 1'b0);
        cycle(1'b1, 4'd2, 32'hC, 32'hD, 16'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset illegal_count", 64'(illegal_count), 64'd0);
        q.delete();
        cnt_model = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle(1'b1);
        cycle(1'b1, 4'd5, 32'h77, 32'h0, 16'hABCD, 1'b1);
        repeat (2) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
